// File: rtl/product_writer.sv
// product_writer: radix-2 Booth 32x32 signed multiplier that keeps its
// 65-bit partial-product word {A, Q, booth} in an external register.
module product_writer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    input  logic [64:0] prod_bus,
    output logic [64:0] prod_in,
    output logic        prod_we,
    output logic        prod_oe,
    output logic        busy,
    output logic        result_ready,
    output logic [63:0] result,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, LOAD, STEP, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] m_q, m_d;
    logic [31:0] q_q, q_d;
    logic [63:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        ready_q, ready_d;
    logic [32:0] acc, addend, sum;

    // A and M are sign-extended to 33 bits so the sum is exact even for M = -2^31.
    always_comb begin
        acc    = {prod_bus[64], prod_bus[64:33]};
        addend = {m_q[31], m_q};
        sum    = (prod_bus[1:0] == 2'b01) ? acc + addend :
                 (prod_bus[1:0] == 2'b10) ? acc - addend : acc;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        m_d      = m_q;
        q_d      = q_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        ready_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = 5'd0;
                state_d = STEP;
            end
            STEP: begin
                cnt_d   = cnt_q + 5'd1;
                state_d = (cnt_q == 5'd31) ? DONE : STEP;
            end
            DONE: begin
                result_d = prod_bus[64:1];
                ovf_d    = prod_bus[64:33] != {32{prod_bus[32]}};
                ready_d  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            m_q      <= 32'd0;
            q_q      <= 32'd0;
            result_q <= 64'd0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            m_q      <= m_d;
            q_q      <= q_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            ready_q  <= ready_d;
        end
    end

    // Shifting {S, Q, booth} right by one and keeping 65 bits drops the old booth bit.
    assign prod_in      = (state_q == LOAD) ? {32'd0, q_q, 1'b0} :
                          (state_q == STEP) ? {sum, prod_bus[32:1]} : 65'd0;
    assign prod_we      = (state_q == LOAD) || (state_q == STEP);
    assign prod_oe      = (state_q == STEP) || (state_q == DONE);
    assign busy         = state_q != IDLE;
    assign result_ready = ready_q;
    assign result       = result_q;
    assign overflow     = ovf_q;

endmodule

// File: doc/product_writer.md
PRODUCT_WRITER -- requirements
Module: product_writer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (32x32 signed multiply, 65-bit product word).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 multiplicand  input  32  signed operand M; latched on accepted start.
REQ-006 multiplier  input  32  signed operand Q; written to the product register in LOAD.
REQ-007 prod_bus  input  65  read-back of the external 65-bit product register; valid while prod_oe=1.
REQ-008 prod_in  output  65  next product word driven to the product register.
REQ-009 prod_we  output  1  product register write enable.
REQ-010 prod_oe  output  1  product register output enable (read request).
REQ-011 busy  output  1  high while a multiply is in progress.
REQ-012 result_ready  output  1  one-cycle pulse; result and overflow valid.
REQ-013 result  output  64  signed product M*Q.
REQ-014 overflow  output  1  product does not fit in 32-bit signed.

Function
REQ-015 The product word format SHALL be [64:33] = accumulator A, [32:1] = Q, [0] = Booth bit.
REQ-016 The FSM SHALL have states IDLE, LOAD, STEP, DONE plus a 5-bit step counter.
REQ-017 IDLE: start=1 at edge SHALL latch M into an internal register and go to LOAD; start=0 stays IDLE.
REQ-018 LOAD: prod_in={32'b0, multiplier, 1'b0}, prod_we=1, prod_oe=0; next edge -> STEP, counter=0.
REQ-019 STEP: prod_oe=1, prod_we=1; prod_in SHALL be computed combinationally from prod_bus.
REQ-020 Each step, on prod_bus[1:0]: 01 -> S = A+M; 10 -> S = A-M; 00/11 -> S = A; S is computed exact at 33 bits (sign-extended operands).
REQ-021 prod_in SHALL be the 66-bit value {S, prod_bus[32:1], prod_bus[0]}, arithmetic-shifted right 1 with the 33-bit sign of S, truncated to 65 bits. This gives an exact result for M = -2^31.
REQ-022 Counter SHALL increment each STEP edge; the edge with counter=31 SHALL go to DONE (exactly 32 writes in STEP).
REQ-023 DONE: prod_oe=1, prod_we=0; next edge SHALL register result=prod_bus[64:1], overflow=(result[63:32] != {32{result[31]}}), set result_ready=1, go to IDLE.
REQ-024 result_ready SHALL be high for exactly one cycle; result and overflow SHALL hold until the next completion or reset.
REQ-025 busy SHALL be 1 in LOAD, STEP, DONE and 0 in IDLE.
REQ-026 prod_we, prod_oe and busy SHALL be decoded from registered state only (Moore). prod_in SHALL be 0 in IDLE and DONE.
REQ-027 Latency: start accepted at edge E0 -> result_ready high in the cycle after edge E34.
REQ-028 start while busy SHALL be ignored and SHALL NOT be queued.
REQ-029 start high in the IDLE cycle in which result_ready=1 SHALL be accepted (back-to-back).
REQ-030 Operand changes after acceptance SHALL NOT affect the in-flight multiply: M is latched and Q is captured in LOAD.

Reset
REQ-031 reset=0 SHALL immediately force IDLE, counter=0, latched M=0, prod_in=0, prod_we=0, prod_oe=0, busy=0, result_ready=0, result=0, overflow=0.
REQ-032 Reset mid-operation SHALL abort without further register writes; the product register contents are not cleared by this block.
REQ-033 After reset deassertion, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-034 M=3, Q=5 -> result=0x0000_0000_0000_000F, overflow=0, result_ready 34 edges after acceptance.
REQ-035 M=-7, Q=6 -> result=0xFFFF_FFFF_FFFF_FFD6, overflow=0. M=0x7FFF_FFFF, Q=0x7FFF_FFFF -> 0x3FFF_FFFF_0000_0001, overflow=1.
REQ-036 M=Q=0x8000_0000 -> result=0x4000_0000_0000_0000, overflow=1. M=0x8000_0000, Q=1 -> 0xFFFF_FFFF_8000_0000, overflow=0.
REQ-037 reset pulsed low at step 10 -> all outputs 0 at once, no prod_we after. A new start (2*3) -> result=6.
REQ-038 start re-asserted mid-run (ignored: one result_ready only), then start in the result_ready cycle -> second multiply completes 34 edges later.
REQ-039 Scoreboard: every prod_we write in STEP SHALL match a reference Booth model, checked against 1000 random signed operand pairs.
